// File: rtl/axi_wr_bridge.sv
// Write-request responder: turns one cache/uncache write into one AXI
// write transaction (AW, W burst, B), with busy/address for RAW blocking.
module axi_wr_bridge #(
    parameter int LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wr_req,
    input  logic [2:0]              wr_type,
    input  logic [31:0]             wr_addr,
    input  logic [3:0]              wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic                    wr_rdy,
    output logic                    wr_done,
    output logic                    wr_busy,
    output logic [31:0]             wr_busy_addr,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int BW = $clog2(LINE_WORDS) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [3:0]              strb_q, strb_d;
    logic [32*LINE_WORDS-1:0] data_q, data_d;
    logic                    line_q, line_d;
    logic                    aw_pend_q, aw_pend_d;
    logic                    w_fin_q, w_fin_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic                    done_q, done_d;

    logic        aw_hs;
    logic        w_hs;
    logic        last_hs;
    logic        is_line;
    logic [31:0] wdata_mux;

    assign wr_rdy       = (state_q == S_IDLE);
    assign wr_busy      = (state_q != S_IDLE);
    assign wr_busy_addr = addr_q;
    assign wr_done      = done_q;

    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = size_q;
    assign awvalid = (state_q == S_SEND) & aw_pend_q;

    assign wvalid  = (state_q == S_SEND) & ~w_fin_q;
    assign wlast   = wvalid & (8'(beat_q) == len_q);
    assign wstrb   = strb_q;
    assign wdata   = wdata_mux;
    assign bready  = (state_q == S_RESP);

    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign last_hs = w_hs & wlast;
    assign is_line = (wr_type == 3'b100);

    // Single writes always present word 0 regardless of the beat counter
    always_comb begin
        wdata_mux = data_q[31:0];
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (line_q && beat_q == BW'(i)) begin
                wdata_mux = data_q[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        strb_d    = strb_q;
        data_d    = data_q;
        line_d    = line_q;
        aw_pend_d = aw_pend_q;
        w_fin_d   = w_fin_q;
        beat_d    = beat_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    addr_d    = wr_addr;
                    data_d    = wr_data;
                    line_d    = is_line;
                    len_d     = is_line ? 8'(LINE_WORDS - 1) : 8'd0;
                    strb_d    = is_line ? 4'hF : wr_wstrb;
                    if (wr_type == 3'b000) begin
                        size_d = 3'd0;
                    end else if (wr_type == 3'b001) begin
                        size_d = 3'd1;
                    end else begin
                        size_d = 3'd2;
                    end
                    aw_pend_d = 1'b1;
                    w_fin_d   = 1'b0;
                    beat_d    = '0;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (aw_hs) begin
                    aw_pend_d = 1'b0;
                end
                if (w_hs) begin
                    if (wlast) begin
                        w_fin_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                // AW and last W may finish in either order or together
                if ((~aw_pend_q | aw_hs) & (w_fin_q | last_hs)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bvalid) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            strb_q    <= '0;
            data_q    <= '0;
            line_q    <= 1'b0;
            aw_pend_q <= 1'b0;
            w_fin_q   <= 1'b0;
            beat_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            strb_q    <= strb_d;
            data_q    <= data_d;
            line_q    <= line_d;
            aw_pend_q <= aw_pend_d;
            w_fin_q   <= w_fin_d;
            beat_q    <= beat_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: doc/axi_wr_bridge.md
Name:
axi_wr_bridge

Overview:
- Responder end of the cache/uncache write-request interface: `wr_req`/`wr_type`/`wr_addr`/`wr_wstrb`/`wr_data` in, `wr_rdy` out.
- Converts each accepted request into one AXI write transaction (AW, W burst, B).
- Sits between the `cache_select_dm`/`cache_select_im` write outputs and the AXI master port.
- Holds at most one request in flight. It exports busy status and the in-flight address so the read path can block read-after-write hazards.

Parameters:
- `LINE_WORDS`, default 4: 32-bit words per cache line. It sets the burst length and the `wr_data` width.

Ports:
- `clk` input 1: system clock; all logic on the rising edge.
- `resetn` input 1: synchronous reset, active-low.
- `wr_req` input 1: write request valid.
- `wr_type` input 3: 000 byte, 001 half, 010 word, 100 cache line; other codes are treated as word.
- `wr_addr` input 32: physical address; byte address for single writes, line-aligned for line writes.
- `wr_wstrb` input 4: byte strobes for single writes; ignored for line writes.
- `wr_data` input 32*LINE_WORDS: write data; word i occupies bits [32i+31:32i]; single writes use only [31:0].
- `wr_rdy` output 1: request accepted this cycle when `wr_req` is also high.
- `wr_done` output 1: one-cycle pulse when the B response is received.
- `wr_busy` output 1: a transaction is in flight.
- `wr_busy_addr` output 32: latched `wr_addr` of the in-flight transaction.
- `awaddr` output 32: AXI write address.
- `awlen` output 8: burst length minus 1.
- `awsize` output 3: beat size.
- `awvalid` output 1: AW channel valid.
- `awready` input 1: AW channel ready.
- `wdata` output 32: write beat data.
- `wstrb` output 4: write beat strobes.
- `wlast` output 1: last beat of the burst.
- `wvalid` output 1: W channel valid.
- `wready` input 1: W channel ready.
- `bvalid` input 1: write response valid; `bresp` is ignored.
- `bready` output 1: write response ready.

Behaviour:
- State machine:
  - IDLE: `wr_rdy`=1. On `wr_req`&`wr_rdy`, latch type, addr, wstrb and data, set `aw_pend`=1 and `beat`=0, go to SEND.
  - SEND: `awvalid` = `aw_pend`; `wvalid` = 1 until the last W handshake.
  - SEND to RESP: when the AW handshake (`awvalid`&`awready`) and the last-beat W handshake have both occurred. They may happen in the same cycle or in either order.
  - RESP: `bready`=1. On `bvalid`, go to IDLE and assert `wr_done` for exactly one cycle.
- Ready and busy:
  - `wr_rdy` = (state==IDLE). `wr_rdy` is combinational from state and independent of `wr_req`.
  - `wr_busy` = (state!=IDLE).
- Request latency: the request is accepted in cycle N. `awvalid` and `wvalid` first rise in cycle N+1.
- AW fields:
  - Line write: `awlen`=LINE_WORDS-1, `awsize`=2.
  - Single write: `awlen`=0; `awsize` = 0, 1 or 2 for byte, half or word.
  - `awaddr` = latched addr, unmodified.
- `aw_pend`: cleared on the AW handshake. It is never re-asserted within the transaction.
- W beats:
  - `beat` is a counter of width clog2(LINE_WORDS)+1; it increments on each W handshake.
  - `wdata` = latched data word[`beat`]; single writes always use word 0.
  - `wstrb` = 4'hF for line writes, latched wstrb for single writes.
  - `wlast` = (`beat`==`awlen`).
  - `wvalid` drops in the cycle after the `wlast` handshake.
- Channel independence: W beats may complete before AW; the bridge does not wait for `awready` before presenting W.
- Stability: once asserted, `awvalid` and `wvalid` hold until handshake, and their payloads stay stable.
- Requester side: the requester may change the `wr_*` inputs in the cycle after acceptance. `wr_req` while busy is ignored; the requester holds it.
- `wr_req` in the same cycle as `bvalid`: not accepted (`wr_rdy`=0). It is accepted one cycle later, so the minimum spacing is 1 bubble.
- Reset values (after a clock edge with `resetn`=0): state=IDLE, `awvalid`=`wvalid`=`bready`=`wr_done`=0, `wr_busy`=0, `wr_rdy`=1. `wr_busy_addr`, `awaddr`, `awlen`, `awsize`, `wdata`, `wstrb` and `wlast` are all 0.
- Reset mid-transaction: the in-flight transaction is abandoned immediately at that edge, with no completion pulse. The AXI slave is reset by the same `resetn`.

Test Plan:
- Word store: `wr_type`=010, addr=0x1FAF_0004, wstrb=F, data=0xDEADBEEF, all readies high.
  - Expect: AW with len=0, size=2, addr=0x1FAF_0004; one beat with `wlast`=1.
  - Expect: `wr_done` 3 cycles after accept; `wr_rdy` low throughout.
- Byte store: `wr_type`=000, addr=0x0000_0013, wstrb=1000.
  - Expect: `awsize`=0, `wstrb`=1000, `wdata`=`wr_data`[31:0].
- Line write with LINE_WORDS=4, addr=0x0000_1000, data words 0x11111111..0x44444444, `wready` toggling 1,0,1,0:
  - Expect: awlen=3, size=2; beats in order 0x11111111..0x44444444; `wlast` only on the 4th; `wdata` held stable during stalls.
- `awready` held low 5 cycles while W completes first:
  - Expect: RESP entered only after the AW handshake; `bready` never high before it.
- Back-to-back: second `wr_req` asserted during RESP.
  - Expect: accepted the cycle after `bvalid`; `wr_busy_addr` updates to the new addr.
- `resetn` low for 1 cycle mid-burst after beat 1:
  - Expect: next cycle `awvalid`=`wvalid`=`bready`=0, `wr_rdy`=1, no `wr_done`; a new request then completes normally.
